mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage engine of the 5-stage pipeline, fed by the EX_MEM buffer and feeding MEM_WB.
//  Owns the 16-bit data memory and the stack pointer (SP).
//  Executes loads, stores, PUSH/POP, 32-bit PC push/pop (CALL/RET/INT/RTI) and flags push/pop.
//  Returns popped PC to IF, popped flags to EX, and raises the memory exception (EPC/CAUSE).
// PARAMETERS
//  ADDR_W   11              data-memory address width; DEPTH = 2**ADDR_W words of 16 bits
//  SP_INIT  (2**ADDR_W)-1   SP value after reset (top of stack, stack empty)
// PORTS
//  clk                 in   1   single clock, all state on rising edge
//  reset               in   1   asynchronous, active-low; 0 = reset
//  mem_read_in         in   1   read access this cycle
//  mem_write_in        in   1   write access this cycle
//  mem_type_in         in   1   0 = 16-bit access, 1 = 32-bit (two words, two cycles)
//  SP_src_in           in   2   00 none, 01 push (SP decrements), 10 pop (SP increments), 11 = 00
//  mem_addr_src_in     in   1   0 = address from addr_in, 1 = address from SP
//  mem_data_src_in     in   1   0 = write data_in, 1 = write PC_in
//  addr_in             in   16  effective address (Rsrc value)
//  data_in             in   16  store data (Rdst value)
//  PC_in               in   32  PC of the instruction in MEM
//  flags_push_pop_in   in   1   access carries flags; push writes {13'b0,flags_in}
//  flags_in            in   3   {C,N,Z} to push
//  PC_push_pop_in      in   1   32-bit pop targets the PC
//  mem_data_out        out  16  word read this cycle (comb.)
//  PC_popedValue_out   out  32  assembled popped PC
//  pop_pc_out          out  1   PC_popedValue_out valid this cycle (1-cycle pulse)
//  POP_flags_val_out   out  3   popped flags = word[2:0]
//  is_POP_flags_out    out  1   POP_flags_val_out valid (1-cycle pulse)
//  SP_out              out  ADDR_W  current SP
//  stall_out           out  1   hold IF/ID/EX and EX_MEM this cycle
//  exception_out       out  1   faulting access this cycle (comb.)
//  EPC_out             out  32  PC of last faulting instruction (registered)
//  CAUSE_out           out  4   1 = empty-stack pop, 2 = address > DEPTH-1 (registered)
// BEHAVIOUR
//  Reset: state=IDLE, SP=SP_INIT, hold regs=0, EPC_out=0, CAUSE_out=0.
//   All pulses and stall_out are 0. Memory contents are not cleared.
//  Access = mem_read_in|mem_write_in. Read and write both high => treated as write.
//  Address: mem_addr_src_in=1 -> SP (push) or SP+1 (pop). Otherwise addr_in[ADDR_W-1:0].
//  Memory: synchronous write, asynchronous read.
//  16-bit push: mem[SP]<=wdata; SP<=SP-1. 16-bit pop: SP<=SP+1; mem_data_out=mem[SP+1], same cycle.
//  FSM IDLE/SECOND, used only when mem_type_in=1:
//   IDLE + 32-bit access, no fault: stall_out=1, do word 1, latch ctrl/PC/word 1, go SECOND.
//   SECOND: stall_out=0, do word 2 from latched ctrl (inputs ignored), go IDLE.
//   Push order: cycle 1 writes PC[31:16] at SP, cycle 2 writes PC[15:0] at SP-1; SP -= 2 total.
//   Pop order: cycle 1 reads low at SP+1, cycle 2 reads high at SP+2; SP += 2 total.
//   Pop result: pop_pc_out (if PC_push_pop_in) pulses in SECOND, value {high,low}.
//  Flags pop (16-bit, flags_push_pop_in=1): is_POP_flags_out pulses in the pop cycle.
//  Faults are checked in IDLE only, for the whole access:
//   Pop with SP+words > SP_INIT -> CAUSE 1.
//   Non-SP address > DEPTH-1 (addr_in[15:ADDR_W]!=0) -> CAUSE 2.
//   On fault: exception_out=1 that cycle, no write, SP unchanged, no stall, no pulses.
//   Clock edge then loads EPC_out<=PC_in and CAUSE_out<=cause. EPC/CAUSE hold until next fault.
//  SP wraps modulo 2**ADDR_W on push (overflow is not detected).
//  reset low mid-access: FSM to IDLE at once; half-done 32-bit access abandoned; memory keeps any word written.
// TESTING
//  Store 0xBEEF @0x010, then load @0x010 -> mem_data_out=0xBEEF, SP_out=0x7FF.
//  PUSH 0x1234, POP -> SP 0x7FF->0x7FE->0x7FF, mem_data_out=0x1234, mem[0x7FF]=0x1234.
//  CALL push PC_in=0x0001_0020 -> stall_out=1 for exactly 1 cycle, mem[0x7FF]=0x0001, mem[0x7FE]=0x0020, SP=0x7FD.
//  RET pop from SP=0x7FD -> pop_pc_out=1 in cycle 2 with PC_popedValue_out=0x0001_0020, SP=0x7FF.
//  Pop at SP=0x7FF, PC_in=0x55 -> exception_out=1, EPC_out=0x55, CAUSE_out=1, SP stays 0x7FF.
//  Load addr_in=0x0800 -> CAUSE_out=2.
//  reset=0 during SECOND of a push -> state IDLE, SP=0x7FF, stall_out=0, no pop_pc_out.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage engine: owns the 16-bit data memory and the stack pointer.
// Handles loads/stores, 16-bit PUSH/POP, two-cycle 32-bit PC push/pop,
// flags push/pop, and the memory exception (EPC/CAUSE).
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned SP_INIT = (2**ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_type_in,
  input  logic [1:0]        SP_src_in,
  input  logic              mem_addr_src_in,
  input  logic              mem_data_src_in,
  input  logic [15:0]       addr_in,
  input  logic [15:0]       data_in,
  input  logic [31:0]       PC_in,
  input  logic              flags_push_pop_in,
  input  logic [2:0]        flags_in,
  input  logic              PC_push_pop_in,
  output logic [15:0]       mem_data_out,
  output logic [31:0]       PC_popedValue_out,
  output logic              pop_pc_out,
  output logic [2:0]        POP_flags_val_out,
  output logic              is_POP_flags_out,
  output logic [ADDR_W-1:0] SP_out,
  output logic              stall_out,
  output logic              exception_out,
  output logic [31:0]       EPC_out,
  output logic [3:0]        CAUSE_out
);

  localparam int unsigned       DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(SP_INIT);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sp;
  logic [15:0]       mem [DEPTH];

  // Control latched at the first word of a 32-bit access
  logic              lat_write, lat_push, lat_pop, lat_asrc, lat_pcpp;
  logic [15:0]       lat_wdata2, lat_word1;
  logic [ADDR_W-1:0] lat_addr2;

  logic              access, in_push, in_pop, pop_fault, addr_fault, fault;
  logic [ADDR_W:0]   sp_after_pop;
  logic              cur_act, cur_wr, cur_push, cur_pop, cur_asrc;
  logic [ADDR_W-1:0] cur_addr_direct, mem_addr;
  logic [15:0]       cur_wdata, wdata2;
  logic              we;

  // Fault detection for the whole access, evaluated in IDLE only
  always_comb begin
    access       = mem_read_in | mem_write_in;
    in_push      = (SP_src_in == 2'b01);
    in_pop       = (SP_src_in == 2'b10);
    sp_after_pop = {1'b0, sp} + (mem_type_in ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
    pop_fault    = access & in_pop & (sp_after_pop > {1'b0, SP_RST});
    addr_fault   = access & ~mem_addr_src_in & (addr_in[15:ADDR_W] != '0);
    fault        = (state == IDLE) & (pop_fault | addr_fault);
  end

  // Per-cycle access control: live inputs in IDLE, latched copy in SECOND.
  // SP moves once per word, so the SP-relative address rule is identical in
  // both cycles (push at SP, pop at SP+1).
  always_comb begin
    wdata2 = flags_push_pop_in ? {13'b0, flags_in} :
             mem_data_src_in   ? PC_in[15:0] : data_in;
    if (state == IDLE) begin
      cur_act         = access & ~fault;
      cur_wr          = mem_write_in;
      cur_push        = in_push;
      cur_pop         = in_pop;
      cur_asrc        = mem_addr_src_in;
      cur_addr_direct = addr_in[ADDR_W-1:0];
      if (flags_push_pop_in)
        cur_wdata = {13'b0, flags_in};
      else if (mem_data_src_in)
        cur_wdata = mem_type_in ? PC_in[31:16] : PC_in[15:0];
      else
        cur_wdata = data_in;
    end else begin
      cur_act         = 1'b1;
      cur_wr          = lat_write;
      cur_push        = lat_push;
      cur_pop         = lat_pop;
      cur_asrc        = lat_asrc;
      cur_addr_direct = lat_addr2;
      cur_wdata       = lat_wdata2;
    end
    mem_addr = cur_asrc ? (cur_pop ? sp + ADDR_W'(1) : sp) : cur_addr_direct;
    we       = cur_act & cur_wr & reset;
  end

  // Asynchronous read port and derived outputs
  always_comb begin
    mem_data_out      = mem[mem_addr];
    PC_popedValue_out = {mem_data_out, lat_word1};
    pop_pc_out        = (state == SECOND) & ~lat_write & lat_pcpp;
    POP_flags_val_out = mem_data_out[2:0];
    is_POP_flags_out  = (state == IDLE) & access & ~mem_write_in & in_pop &
                        flags_push_pop_in & ~mem_type_in & ~fault;
    stall_out         = (state == IDLE) & access & mem_type_in & ~fault;
    exception_out     = fault;
    SP_out            = sp;
  end

  // Synchronous write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[mem_addr] <= cur_wdata;
  end

  // FSM, stack pointer, exception registers and 32-bit hold registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sp         <= SP_RST;
      EPC_out    <= '0;
      CAUSE_out  <= '0;
      lat_write  <= 1'b0;
      lat_push   <= 1'b0;
      lat_pop    <= 1'b0;
      lat_asrc   <= 1'b0;
      lat_pcpp   <= 1'b0;
      lat_wdata2 <= '0;
      lat_word1  <= '0;
      lat_addr2  <= '0;
    end else begin
      if (cur_act && cur_push)
        sp <= sp - ADDR_W'(1);
      else if (cur_act && cur_pop)
        sp <= sp + ADDR_W'(1);
      if (fault) begin
        EPC_out   <= PC_in;
        CAUSE_out <= pop_fault ? 4'd1 : 4'd2;
      end
      case (state)
        IDLE: begin
          if (stall_out) begin
            state      <= SECOND;
            lat_write  <= mem_write_in;
            lat_push   <= in_push;
            lat_pop    <= in_pop;
            lat_asrc   <= mem_addr_src_in;
            lat_pcpp   <= PC_push_pop_in;
            lat_wdata2 <= wdata2;
            lat_word1  <= mem_data_out;
            lat_addr2  <= addr_in[ADDR_W-1:0] + ADDR_W'(1);
          end
        end
        SECOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected output
// events into a queue; a negedge monitor pops and compares them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_in, mem_write_in, mem_type_in;
  logic [1:0]  SP_src_in;
  logic        mem_addr_src_in, mem_data_src_in;
  logic [15:0] addr_in, data_in;
  logic [31:0] PC_in;
  logic        flags_push_pop_in;
  logic [2:0]  flags_in;
  logic        PC_push_pop_in;
  logic [15:0] mem_data_out;
  logic [31:0] PC_popedValue_out;
  logic        pop_pc_out;
  logic [2:0]  POP_flags_val_out;
  logic        is_POP_flags_out;
  logic [10:0] SP_out;
  logic        stall_out, exception_out;
  logic [31:0] EPC_out;
  logic [3:0]  CAUSE_out;

  mem_access_unit #(.ADDR_W(11)) dut (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_type_in(mem_type_in), .SP_src_in(SP_src_in),
    .mem_addr_src_in(mem_addr_src_in), .mem_data_src_in(mem_data_src_in),
    .addr_in(addr_in), .data_in(data_in), .PC_in(PC_in),
    .flags_push_pop_in(flags_push_pop_in), .flags_in(flags_in),
    .PC_push_pop_in(PC_push_pop_in),
    .mem_data_out(mem_data_out), .PC_popedValue_out(PC_popedValue_out),
    .pop_pc_out(pop_pc_out), .POP_flags_val_out(POP_flags_val_out),
    .is_POP_flags_out(is_POP_flags_out), .SP_out(SP_out),
    .stall_out(stall_out), .exception_out(exception_out),
    .EPC_out(EPC_out), .CAUSE_out(CAUSE_out)
  );

  always #5 clk = ~clk;

  localparam int K_READ  = 0;
  localparam int K_STALL = 1;
  localparam int K_PCPOP = 2;
  localparam int K_FLAGS = 3;
  localparam int K_EXC   = 4;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
    logic [10:0] sp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_ev(input string name, input int kind,
                           input logic [31:0] val, input logic [10:0] sp);
    exp_t e;
    e.name = name; e.kind = kind; e.val = val; e.sp = sp;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    mem_read_in = 0; mem_write_in = 0; mem_type_in = 0; SP_src_in = 2'b00;
    mem_addr_src_in = 0; mem_data_src_in = 0; addr_in = '0; data_in = '0;
    PC_in = '0; flags_push_pop_in = 0; flags_in = '0; PC_push_pop_in = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor: one observable event per cycle, highest priority first
  always begin
    int          k;
    logic [31:0] v;
    bit          ev;
    exp_t        e;
    @(negedge clk);
    ev = 1'b1;
    k  = K_READ;
    v  = '0;
    if (exception_out)              k = K_EXC;
    else if (stall_out)             k = K_STALL;
    else if (pop_pc_out)          begin k = K_PCPOP; v = PC_popedValue_out; end
    else if (is_POP_flags_out)    begin k = K_FLAGS; v = {29'b0, POP_flags_val_out}; end
    else if (mem_read_in && !mem_write_in) begin k = K_READ; v = {16'b0, mem_data_out}; end
    else ev = 1'b0;
    if (ev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got kind %0d val %h sp %h, expected no event", k, v, SP_out);
      end else begin
        e = q.pop_front();
        if (e.kind != k || e.val !== v || e.sp !== SP_out) begin
          errors++;
          $display("FAIL %s: got kind %0d val %h sp %h, expected kind %0d val %h sp %h",
                   e.name, k, v, SP_out, e.kind, e.val, e.sp);
        end
      end
    end
  end

  initial begin
    idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sp",    {21'b0, SP_out}, 32'h7FF);
    chk("rst_stall", {31'b0, stall_out}, 32'h0);
    chk("rst_epc",   EPC_out, 32'h0);
    chk("rst_cause", {28'b0, CAUSE_out}, 32'h0);
    chk("rst_pulses", {30'b0, pop_pc_out, is_POP_flags_out}, 32'h0);
    reset = 1'b1;
    step();

    // Store 0xBEEF @0x010, then load it back
    mem_write_in = 1; addr_in = 16'h0010; data_in = 16'hBEEF;
    step(); idle();
    expect_ev("load_beef", K_READ, 32'h0000BEEF, 11'h7FF);
    mem_read_in = 1; addr_in = 16'h0010;
    step(); idle();

    // PUSH 0x1234 then POP
    mem_write_in = 1; SP_src_in = 2'b01; mem_addr_src_in = 1; data_in = 16'h1234;
    step(); idle();
    chk("push_sp", {21'b0, SP_out}, 32'h7FE);
    expect_ev("pop_1234", K_READ, 32'h00001234, 11'h7FE);
    mem_read_in = 1; SP_src_in = 2'b10; mem_addr_src_in = 1;
    step(); idle();
    chk("pop_sp", {21'b0, SP_out}, 32'h7FF);

    // CALL: 32-bit PC push, one stall cycle
    expect_ev("call_stall", K_STALL, 32'h0, 11'h7FF);
    mem_write_in = 1; mem_type_in = 1; SP_src_in = 2'b01; mem_addr_src_in = 1;
    mem_data_src_in = 1; PC_in = 32'h0001_0020;
    step(); idle();
    step();
    chk("call_sp", {21'b0, SP_out}, 32'h7FD);
    expect_ev("call_hi", K_READ, 32'h00000001, 11'h7FD);
    mem_read_in = 1; addr_in = 16'h07FF;
    step();
    expect_ev("call_lo", K_READ, 32'h00000020, 11'h7FD);
    addr_in = 16'h07FE;
    step(); idle();

    // RET: 32-bit PC pop
    expect_ev("ret_stall", K_STALL, 32'h0, 11'h7FD);
    expect_ev("ret_pc", K_PCPOP, 32'h0001_0020, 11'h7FE);
    mem_read_in = 1; mem_type_in = 1; SP_src_in = 2'b10; mem_addr_src_in = 1;
    PC_push_pop_in = 1;
    step(); idle();
    step();
    chk("ret_sp", {21'b0, SP_out}, 32'h7FF);

    // Pop from empty stack
    expect_ev("empty_pop_exc", K_EXC, 32'h0, 11'h7FF);
    mem_read_in = 1; SP_src_in = 2'b10; mem_addr_src_in = 1; PC_in = 32'h55;
    step(); idle();
    chk("empty_pop_epc", EPC_out, 32'h55);
    chk("empty_pop_cause", {28'b0, CAUSE_out}, 32'h1);
    chk("empty_pop_sp", {21'b0, SP_out}, 32'h7FF);

    // Out-of-range load address
    expect_ev("range_exc", K_EXC, 32'h0, 11'h7FF);
    mem_read_in = 1; addr_in = 16'h0800; PC_in = 32'h99;
    step(); idle();
    chk("range_cause", {28'b0, CAUSE_out}, 32'h2);
    chk("range_epc", EPC_out, 32'h99);

    // Flags push then flags pop
    mem_write_in = 1; SP_src_in = 2'b01; mem_addr_src_in = 1;
    flags_push_pop_in = 1; flags_in = 3'b101;
    step(); idle();
    chk("flags_push_sp", {21'b0, SP_out}, 32'h7FE);
    expect_ev("flags_pop", K_FLAGS, 32'h5, 11'h7FE);
    mem_read_in = 1; SP_src_in = 2'b10; mem_addr_src_in = 1; flags_push_pop_in = 1;
    step(); idle();
    chk("flags_pop_sp", {21'b0, SP_out}, 32'h7FF);

    // 32-bit pop with only one word on the stack faults
    mem_write_in = 1; SP_src_in = 2'b01; mem_addr_src_in = 1; data_in = 16'hAAAA;
    step(); idle();
    expect_ev("short_pop_exc", K_EXC, 32'h0, 11'h7FE);
    mem_read_in = 1; mem_type_in = 1; SP_src_in = 2'b10; mem_addr_src_in = 1;
    PC_push_pop_in = 1; PC_in = 32'h77;
    step(); idle();
    chk("short_pop_cause", {28'b0, CAUSE_out}, 32'h1);
    chk("short_pop_epc", EPC_out, 32'h77);
    chk("short_pop_sp", {21'b0, SP_out}, 32'h7FE);
    expect_ev("pop_aaaa", K_READ, 32'h0000AAAA, 11'h7FE);
    mem_read_in = 1; SP_src_in = 2'b10; mem_addr_src_in = 1;
    step(); idle();

    // Reset during the second cycle of a 32-bit push
    expect_ev("abort_stall", K_STALL, 32'h0, 11'h7FF);
    mem_write_in = 1; mem_type_in = 1; SP_src_in = 2'b01; mem_addr_src_in = 1;
    mem_data_src_in = 1; PC_in = 32'h1234_5678;
    step(); idle();
    reset = 1'b0;
    #1;
    chk("abort_stall_low", {31'b0, stall_out}, 32'h0);
    chk("abort_sp", {21'b0, SP_out}, 32'h7FF);
    chk("abort_no_pop_pc", {31'b0, pop_pc_out}, 32'h0);
    chk("abort_epc", EPC_out, 32'h0);
    step();
    reset = 1'b1;
    step();
    expect_ev("abort_word1_kept", K_READ, 32'h00001234, 11'h7FF);
    mem_read_in = 1; addr_in = 16'h07FF;
    step(); idle();

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
